// File: rtl/clint_core_pkg.sv
// ----------------------------------------------------------------------------
// clint_core_pkg
//   Shared definitions for the core-local interruptor:
//   - register offsets within the CLINT window
//   - response FSM state encoding
//   - byte-strobe merge helper shared by mtime and mtimecmp write paths
// ----------------------------------------------------------------------------
package clint_core_pkg;

    localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } clint_state_e;

    // Replace each byte of old_val whose strobe bit is set with the matching
    // byte of wdata; unstrobed bytes keep old_val.
    function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                               input logic [63:0] wdata,
                                               input logic [7:0]  wstrb);
        logic [63:0] res;
        res = old_val;
        for (int b = 0; b < 8; b++) begin
            if (wstrb[b]) begin
                res[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// ----------------------------------------------------------------------------
// clint_timer
//   Free-running mtime counter with prescaler, byte-strobed write port and
//   the registered mtime >= mtimecmp comparator that drives mtip.
// Ports
//   clk, rst     : core clock, synchronous active-high reset
//   i_wen        : write mtime this cycle (already qualified by decode/accept)
//   i_wdata      : write data
//   i_wstrb      : byte enables for the write
//   i_mtimecmp   : current mtimecmp register value
//   o_mtime      : current mtime register value
//   o_mtip       : registered timer interrupt pending
// ----------------------------------------------------------------------------
module clint_timer
    import clint_core_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wen,
    input  logic [63:0] i_wdata,
    input  logic [7:0]  i_wstrb,
    input  logic [63:0] i_mtimecmp,
    output logic [63:0] o_mtime,
    output logic        o_mtip
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [63:0]   r_mtime;
    logic          r_mtip;
    logic          w_tick;
    logic [63:0]   w_mtime_inc;
    logic [63:0]   w_mtime_nxt;

    // The tick fires on the cycle the prescaler wraps back to 0.
    assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
    assign w_mtime_inc = r_mtime + {63'd0, w_tick};
    // A write overrides only the strobed bytes; the rest follow the tick.
    assign w_mtime_nxt = i_wen ? strb_merge(w_mtime_inc, i_wdata, i_wstrb)
                               : w_mtime_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_mtime <= '0;
            r_mtip  <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            r_mtime <= w_mtime_nxt;
            r_mtip  <= (r_mtime >= i_mtimecmp);
        end
    end

    assign o_mtime = r_mtime;
    assign o_mtip  = r_mtip;

endmodule

// File: rtl/clint_core.sv
// ----------------------------------------------------------------------------
// clint_core
//   Core-local interruptor for a single RV64 hart. Memory-mapped responder
//   owning msip, mtimecmp and (via clint_timer) mtime; drives clint_mtip and
//   clint_msip to the CSR unit.
// Ports
//   clk, rst                      : core clock, synchronous active-high reset
//   req_valid/req_ready           : request handshake
//   req_wen, req_addr             : write select, byte offset from CLINT base
//   req_wdata, req_wstrb          : write data and byte enables
//   resp_valid/resp_ready         : response handshake
//   resp_rdata, resp_err          : read data (0 on writes/errors), error flag
//   clint_mtip, clint_msip        : interrupt pending outputs
// ----------------------------------------------------------------------------
module clint_core
    import clint_core_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              clint_mtip,
    output logic              clint_msip
);

    clint_state_e r_state;
    logic         r_req_ready;
    logic         r_resp_valid;
    logic [63:0]  r_resp_rdata;
    logic         r_resp_err;
    logic         r_msip;
    logic [63:0]  r_mtimecmp;

    logic         w_accept;
    logic         w_hit_msip;
    logic         w_hit_cmp;
    logic         w_hit_time;
    logic         w_err;
    logic [63:0]  w_rdata;
    logic [63:0]  w_mtime;
    logic         w_mtip;
    logic         w_time_wen;

    assign w_accept   = req_valid && (r_state == ST_IDLE);

    // Offsets are 8-byte aligned, so an exact match also rejects misalignment.
    assign w_hit_msip = (req_addr == ADDR_W'(CLINT_MSIP_OFS));
    assign w_hit_cmp  = (req_addr == ADDR_W'(CLINT_MTIMECMP_OFS));
    assign w_hit_time = (req_addr == ADDR_W'(CLINT_MTIME_OFS));
    assign w_err      = !(w_hit_msip || w_hit_cmp || w_hit_time);
    assign w_time_wen = w_accept && req_wen && w_hit_time;

    // Read mux sees register values before the accepting edge.
    always_comb begin
        w_rdata = '0;
        if (w_hit_msip) begin
            w_rdata = {63'd0, r_msip};
        end else if (w_hit_cmp) begin
            w_rdata = r_mtimecmp;
        end else if (w_hit_time) begin
            w_rdata = w_mtime;
        end
    end

    clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_wen      (w_time_wen),
        .i_wdata    (req_wdata),
        .i_wstrb    (req_wstrb),
        .i_mtimecmp (r_mtimecmp),
        .o_mtime    (w_mtime),
        .o_mtip     (w_mtip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_msip       <= 1'b0;
            r_mtimecmp   <= '1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_state      <= ST_RESP;
                        r_req_ready  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                        r_resp_rdata <= req_wen ? 64'd0 : w_rdata;
                        if (req_wen && w_hit_msip && req_wstrb[0]) begin
                            r_msip <= req_wdata[0];
                        end
                        if (req_wen && w_hit_cmp) begin
                            r_mtimecmp <= strb_merge(r_mtimecmp, req_wdata, req_wstrb);
                        end
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign clint_mtip = w_mtip;
    assign clint_msip = r_msip;

endmodule
